vlsu_req_sched: RTL and testbench
=================================

// Module: vlsu_req_sched
// PURPOSE
//   Scheduler in front of the VLSU request fragmenter. Arbitrates load and store request streams round-robin.
//   Reserves a meta-buffer credit per issued request and drives the fragmenter's meta_buf_full input.
//   On a load<->store direction switch, drains outstanding metas first so memory ordering is preserved.
// PARAMETERS
//   MetaDepth      4      meta-buffer entries = max outstanding requests (>=1)
//   DrainOnSwitch  1      1: direction switch waits for outstanding count==0; 0: no drain
//   vlsu_req_t     logic  request struct type forwarded to fragmenter unchanged
// PORTS
//   clk_i            in   1                       clock
//   rst_ni           in   1                       reset, asynchronous, active-low
//   ld_req_valid_i   in   1                       load request valid
//   ld_req_ready_o   out  1                       load request accepted this cycle
//   ld_req_i         in   $bits(vlsu_req_t)       load request payload
//   st_req_valid_i   in   1                       store request valid
//   st_req_ready_o   out  1                       store request accepted this cycle
//   st_req_i         in   $bits(vlsu_req_t)       store request payload
//   frag_req_valid_o out  1                       request to fragmenter valid (registered)
//   frag_req_ready_i in   1                       fragmenter accepts
//   frag_req_o       out  $bits(vlsu_req_t)       registered payload to fragmenter
//   meta_deq_i       in   1                       one meta entry retired (pulse)
//   meta_buf_full_o  out  1                       outstanding count == MetaDepth
//   out_cnt_o        out  $clog2(MetaDepth+1)     outstanding (credited) requests
//   err_underflow_o  out  1                       sticky: meta_deq_i seen with count 0
// BEHAVIOUR
//   Reset: state S_IDLE, all ready/valid 0, frag_req_o '0, cnt 0, last_dir=LOAD, drain_dir=LOAD, err 0.
//   Winner (S_IDLE): one valid -> that one; both valid -> direction != last_dir (round-robin).
//   need_drain = DrainOnSwitch && winner_dir != last_dir && cnt != 0.
//   FSM:
//   - S_IDLE: no valid -> stay. need_drain -> S_DRAIN, drain_dir<=winner, no accept.
//     Else if cnt < MetaDepth: winner ready_o=1 (combinational from valid) in the same cycle; capture payload into frag_req_o;
//       last_dir<=winner; -> S_ISSUE. cnt==MetaDepth -> stay, no accept.
//   - S_ISSUE: frag_req_valid_o=1, frag_req_o stable; both ready_o=0. On frag_req_ready_i: cnt+1 -> S_IDLE.
//   - S_DRAIN: ready_o=0. When cnt==0 and drain_dir source valid: accept that source only (locked, no re-arbitration),
//     capture, last_dir<=drain_dir -> S_ISSUE. drain_dir source drops valid (protocol violation) -> stay.
//   Latency: accept at cycle N -> frag_req_valid_o high from N+1; at most 1 request in flight to fragmenter.
//   Throughput: 1 request per 2 cycles max (IDLE accept + ISSUE handshake).
//   Counter: +1 on fragmenter handshake, -1 on meta_deq_i; both same cycle -> unchanged.
//     meta_deq_i with cnt==0 -> cnt stays 0, err_underflow_o<=1 (cleared only by reset).
//     cnt never exceeds MetaDepth: accept requires cnt<MetaDepth; only one request is in flight.
//   meta_buf_full_o = (cnt==MetaDepth), registered-derived, no comb path from inputs.
//   Reset mid-operation: in-flight frag request dropped; cnt cleared; source must re-present.
// TESTING
//   T1 single load: ld valid, payload 0xA5 -> ld_ready@N, frag_valid@N+1, frag_req_o=0xA5; ready@N+1 -> cnt=1.
//   T2 credit full (MetaDepth=4): 4 loads issued, no deq -> full_o=1, 5th load ready_o=0;
//      one meta_deq_i -> full_o=0, 5th load accepted next IDLE cycle.
//   T3 switch drain: 2 loads outstanding, store valid -> S_DRAIN, st_ready_o=0;
//      2x meta_deq_i -> cnt=0, st accepted next cycle, last_dir=STORE.
//   T4 round-robin: ld+st both valid continuously with immediate deq -> grants alternate L,S,L,S.
//      With DrainOnSwitch=0, cnt not required to reach 0.
//   T5 simultaneous: frag handshake and meta_deq_i same cycle at cnt=2 -> cnt stays 2; deq at cnt=0 -> err_underflow_o=1 sticky.
//   T6 reset asserted in S_ISSUE -> frag_req_valid_o=0 immediately (async), cnt=0, next request accepted normally.

Source files
------------

// File: rtl/vlsu_req_sched.sv
// Round-robin load/store scheduler in front of the VLSU request fragmenter.
// Tracks meta-buffer credits and drains outstanding metas on a direction switch.
module vlsu_req_sched #(
  parameter int unsigned MetaDepth     = 4,
  parameter bit          DrainOnSwitch = 1'b1,
  parameter type         vlsu_req_t    = logic
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           ld_req_valid_i,
  output logic                           ld_req_ready_o,
  input  vlsu_req_t                      ld_req_i,
  input  logic                           st_req_valid_i,
  output logic                           st_req_ready_o,
  input  vlsu_req_t                      st_req_i,
  output logic                           frag_req_valid_o,
  input  logic                           frag_req_ready_i,
  output vlsu_req_t                      frag_req_o,
  input  logic                           meta_deq_i,
  output logic                           meta_buf_full_o,
  output logic [$clog2(MetaDepth+1)-1:0] out_cnt_o,
  output logic                           err_underflow_o
);

  localparam int unsigned     CntW   = $clog2(MetaDepth + 1);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MetaDepth);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_e;
  typedef enum logic {DIR_LOAD, DIR_STORE} dir_e;

  state_e          state;
  dir_e            last_dir, drain_dir, winner, accept_dir;
  logic [CntW-1:0] cnt;
  logic            frag_valid_q, err_q;
  logic            any_valid, need_drain, drain_valid;
  logic            idle_accept, drain_accept, accept, frag_hs;

  always_comb begin
    winner = DIR_LOAD;
    if (ld_req_valid_i && st_req_valid_i) begin
      winner = (last_dir == DIR_LOAD) ? DIR_STORE : DIR_LOAD;
    end else if (st_req_valid_i) begin
      winner = DIR_STORE;
    end
  end

  assign any_valid    = ld_req_valid_i || st_req_valid_i;
  assign need_drain   = DrainOnSwitch && any_valid && (winner != last_dir) && (cnt != '0);
  assign idle_accept  = (state == S_IDLE) && any_valid && !need_drain && (cnt < MaxCnt);
  // In drain the grant stays locked to the direction chosen on entry.
  assign drain_valid  = (drain_dir == DIR_LOAD) ? ld_req_valid_i : st_req_valid_i;
  assign drain_accept = (state == S_DRAIN) && (cnt == '0) && drain_valid;
  assign accept       = idle_accept || drain_accept;
  assign accept_dir   = (state == S_DRAIN) ? drain_dir : winner;
  assign frag_hs      = frag_valid_q && frag_req_ready_i;

  assign ld_req_ready_o   = accept && (accept_dir == DIR_LOAD);
  assign st_req_ready_o   = accept && (accept_dir == DIR_STORE);
  assign frag_req_valid_o = frag_valid_q;
  assign out_cnt_o        = cnt;
  assign meta_buf_full_o  = (cnt == MaxCnt);
  assign err_underflow_o  = err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= S_IDLE;
      frag_valid_q <= 1'b0;
      frag_req_o   <= '0;
      last_dir     <= DIR_LOAD;
      drain_dir    <= DIR_LOAD;
    end else begin
      case (state)
        S_IDLE, S_DRAIN: begin
          if (state == S_IDLE && need_drain) begin
            state     <= S_DRAIN;
            drain_dir <= winner;
          end else if (accept) begin
            frag_req_o   <= (accept_dir == DIR_STORE) ? st_req_i : ld_req_i;
            last_dir     <= accept_dir;
            frag_valid_q <= 1'b1;
            state        <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (frag_req_ready_i) begin
            frag_valid_q <= 1'b0;
            state        <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      if (meta_deq_i && cnt == '0) err_q <= 1'b1;
      if (frag_hs && !meta_deq_i) begin
        cnt <= cnt + CntW'(1);
      end else if (meta_deq_i && !frag_hs && cnt != '0) begin
        cnt <= cnt - CntW'(1);
      end
    end
  end

endmodule

// File: tb/tb_vlsu_req_sched.sv
// Scoreboard bench for vlsu_req_sched: directed scenarios followed by random traffic
// checked against a transaction-level model of credits, ordering and arbitration.
module tb_vlsu_req_sched;
  localparam int unsigned DEPTH = 4;
  localparam bit          DRAIN = 1'b1;

  logic       clk = 1'b0;
  logic       rst_ni;
  logic       ld_req_valid_i, ld_req_ready_o, st_req_valid_i, st_req_ready_o;
  logic [7:0] ld_req_i, st_req_i, frag_req_o;
  logic       frag_req_valid_o, frag_req_ready_i, meta_deq_i;
  logic       meta_buf_full_o, err_underflow_o;
  logic [2:0] out_cnt_o;

  vlsu_req_sched #(
    .MetaDepth(DEPTH),
    .DrainOnSwitch(DRAIN),
    .vlsu_req_t(logic [7:0])
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .ld_req_valid_i(ld_req_valid_i), .ld_req_ready_o(ld_req_ready_o), .ld_req_i(ld_req_i),
    .st_req_valid_i(st_req_valid_i), .st_req_ready_o(st_req_ready_o), .st_req_i(st_req_i),
    .frag_req_valid_o(frag_req_valid_o), .frag_req_ready_i(frag_req_ready_i), .frag_req_o(frag_req_o),
    .meta_deq_i(meta_deq_i), .meta_buf_full_o(meta_buf_full_o),
    .out_cnt_o(out_cnt_o), .err_underflow_o(err_underflow_o)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0, n_bad = 0;
  logic [7:0]  exp_q[$];
  bit          rand_en = 1'b0;
  bit          ld_pend = 1'b0, st_pend = 1'b0;
  logic [7:0]  ld_data = '0, st_data = '0;
  // model state: outstanding credits, in-flight flag, last granted direction (1 = store)
  int unsigned m_cnt;
  bit          m_err, m_infl, m_last;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic present_ld(input logic [7:0] d);
    ld_pend = 1'b1; ld_data = d; ld_req_valid_i = 1'b1; ld_req_i = d;
  endtask

  task automatic present_st(input logic [7:0] d);
    st_pend = 1'b1; st_data = d; st_req_valid_i = 1'b1; st_req_i = d;
  endtask

  task automatic wait_clear(input bit is_st, input string nm);
    int unsigned k = 0;
    while ((is_st ? st_pend : ld_pend) && k < 50) begin
      @(posedge clk); #2; k++;
    end
    check(nm, 32'(is_st ? st_pend : ld_pend), 0);
  endtask

  task automatic cyc(input int unsigned n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  // Driver: owns source valids; records accepted payloads as expected fragmenter output.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_ni) begin
        if (ld_req_valid_i && ld_req_ready_o) begin exp_q.push_back(ld_req_i); ld_pend = 1'b0; end
        if (st_req_valid_i && st_req_ready_o) begin exp_q.push_back(st_req_i); st_pend = 1'b0; end
      end
      @(posedge clk); #1;
      if (rand_en) begin
        if (!ld_pend && $urandom_range(0, 2) != 0) begin ld_pend = 1'b1; ld_data = 8'($urandom); end
        if (!st_pend && $urandom_range(0, 2) != 0) begin st_pend = 1'b1; st_data = 8'($urandom); end
        frag_req_ready_i = ($urandom_range(0, 3) != 0);
        meta_deq_i       = ($urandom_range(0, 2) == 0);
      end
      ld_req_valid_i = ld_pend; ld_req_i = ld_data;
      st_req_valid_i = st_pend; st_req_i = st_data;
    end
  end

  // Monitor: checks credits, handshake payload order and grant legality each cycle.
  initial begin
    bit hs, anyv, wdir, exp_acc, acc;
    forever begin
      @(negedge clk);
      if (!rst_ni) begin
        m_cnt = 0; m_err = 1'b0; m_infl = 1'b0; m_last = 1'b0;
        exp_q.delete();
      end else begin
        check("out_cnt", 32'(out_cnt_o), m_cnt);
        check("full", 32'(meta_buf_full_o), 32'(m_cnt == DEPTH));
        check("err_underflow", 32'(err_underflow_o), 32'(m_err));
        check("frag_valid", 32'(frag_req_valid_o), 32'(m_infl));
        hs = m_infl && frag_req_ready_i;
        if (hs) begin
          if (exp_q.size() == 0) check("payload_unexpected", 32'(frag_req_o), 32'hFFFF_FFFF);
          else check("payload", 32'(frag_req_o), 32'(exp_q.pop_front()));
        end
        anyv = ld_req_valid_i || st_req_valid_i;
        wdir = (ld_req_valid_i && st_req_valid_i) ? !m_last : st_req_valid_i;
        exp_acc = !m_infl && anyv && (m_cnt < DEPTH) &&
                  (!(DRAIN && wdir != m_last) || m_cnt == 0);
        acc = ld_req_ready_o || st_req_ready_o;
        check("accept", 32'(acc), 32'(exp_acc));
        if (acc) begin
          check("both_ready", 32'(ld_req_ready_o && st_req_ready_o), 0);
          check("grant_dir", 32'(st_req_ready_o), 32'(wdir));
          m_last = wdir;
          m_infl = 1'b1;
        end
        if (hs) m_infl = 1'b0;
        if (meta_deq_i && m_cnt == 0) m_err = 1'b1;
        if (hs && !meta_deq_i) m_cnt++;
        else if (meta_deq_i && !hs && m_cnt > 0) m_cnt--;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned k;
    rst_ni = 1'b0;
    ld_req_valid_i = 1'b0; st_req_valid_i = 1'b0; ld_req_i = '0; st_req_i = '0;
    frag_req_ready_i = 1'b0; meta_deq_i = 1'b0;
    cyc(3);
    check("rst_cnt", 32'(out_cnt_o), 0);
    check("rst_frag_valid", 32'(frag_req_valid_o), 0);
    check("rst_frag_req", 32'(frag_req_o), 0);
    check("rst_full", 32'(meta_buf_full_o), 0);
    check("rst_err", 32'(err_underflow_o), 0);
    rst_ni = 1'b1;
    cyc(1);

    // single load
    present_ld(8'hA5);
    #1 check("t1_ld_ready", 32'(ld_req_ready_o), 1);
    cyc(1);
    check("t1_frag_valid", 32'(frag_req_valid_o), 1);
    check("t1_frag_req", 32'(frag_req_o), 32'hA5);
    frag_req_ready_i = 1'b1;
    cyc(1);
    check("t1_cnt", 32'(out_cnt_o), 1);

    // credit full and release
    for (int i = 0; i < 3; i++) begin
      present_ld(8'(8'h10 + i));
      wait_clear(1'b0, "t2_ld_timeout");
      cyc(1);
    end
    check("t2_full", 32'(meta_buf_full_o), 1);
    present_ld(8'h20);
    cyc(3);
    check("t2_blocked", 32'(ld_req_ready_o), 0);
    meta_deq_i = 1'b1;
    cyc(1);
    meta_deq_i = 1'b0;
    check("t2_not_full", 32'(meta_buf_full_o), 0);
    check("t2_fifth_ready", 32'(ld_req_ready_o), 1);
    wait_clear(1'b0, "t2_fifth_timeout");
    cyc(1);

    // direction switch drains outstanding metas
    meta_deq_i = 1'b1;
    cyc(2);
    meta_deq_i = 1'b0;
    check("t3_cnt2", 32'(out_cnt_o), 2);
    present_st(8'h5A);
    cyc(2);
    check("t3_st_held", 32'(st_req_ready_o), 0);
    meta_deq_i = 1'b1;
    cyc(2);
    meta_deq_i = 1'b0;
    check("t3_cnt0", 32'(out_cnt_o), 0);
    check("t3_st_ready", 32'(st_req_ready_o), 1);
    wait_clear(1'b1, "t3_st_timeout");
    cyc(1);

    // simultaneous inc/dec, then sticky underflow
    present_st(8'h3C);
    wait_clear(1'b1, "t5_a_timeout");
    cyc(1);
    frag_req_ready_i = 1'b0;
    present_st(8'h3D);
    wait_clear(1'b1, "t5_b_timeout");
    frag_req_ready_i = 1'b1;
    meta_deq_i = 1'b1;
    cyc(1);
    meta_deq_i = 1'b0;
    check("t5_cnt_same", 32'(out_cnt_o), 2);
    meta_deq_i = 1'b1;
    cyc(3);
    meta_deq_i = 1'b0;
    check("t5_err", 32'(err_underflow_o), 1);
    check("t5_cnt_floor", 32'(out_cnt_o), 0);
    cyc(3);
    check("t5_err_sticky", 32'(err_underflow_o), 1);

    // asynchronous reset while a request is in flight
    frag_req_ready_i = 1'b0;
    present_ld(8'h77);
    wait_clear(1'b0, "t6_ld_timeout");
    check("t6_inflight", 32'(frag_req_valid_o), 1);
    rst_ni = 1'b0;
    #1;
    check("t6_rst_valid", 32'(frag_req_valid_o), 0);
    check("t6_rst_cnt", 32'(out_cnt_o), 0);
    check("t6_rst_err", 32'(err_underflow_o), 0);
    @(negedge clk);
    @(posedge clk); #2;
    rst_ni = 1'b1;
    frag_req_ready_i = 1'b1;
    present_ld(8'h78);
    wait_clear(1'b0, "t6_re_timeout");
    cyc(1);
    check("t6_cnt", 32'(out_cnt_o), 1);

    // random traffic
    rand_en = 1'b1;
    cyc(3000);
    rand_en = 1'b0;
    frag_req_ready_i = 1'b1;
    k = 0;
    while ((ld_pend || st_pend || exp_q.size() != 0 || frag_req_valid_o) && k < 200) begin
      meta_deq_i = ~meta_deq_i;
      cyc(1);
      k++;
    end
    meta_deq_i = 1'b0;
    check("flush_pending", 32'(ld_pend || st_pend), 0);
    check("flush_queue", 32'(exp_q.size()), 0);
    cyc(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
